// File: rtl/proc_sequencer.sv
// -----------------------------------------------------------------------------
// proc_sequencer
//   Control sequencer for a small 4-register processor. It accepts an
//   instruction when EXEC is high in IDLE, then steps through up to three
//   execution states. In each state it drives the register-file, bus and ALU
//   control strobes for that step. Every control output is decoded only from
//   the current state and the latched instruction register (Moore outputs).
//
// Ports
//   CLKb      in   clock; state updates on the rising edge
//   RSTb      in   asynchronous active-low reset
//   EXEC      in   start request, sampled only in IDLE
//   INSTR     in   [9:6] opcode, [5:4] Rx, [3:2] Ry, [1:0] ignored
//   ENW       out  register-file write enable (write port address WRA)
//   ENR0      out  register-file read port 0 enable (address RDA0, drives bus)
//   ENR1      out  register-file read port 1 enable (address RDA1, ALU B input)
//   WRA/RDA0/RDA1 out register-file addresses, 00 when not in use
//   EXT       out  put external DIN on the shared bus
//   GOUT      out  put ALU result G on the shared bus
//   GA        out  latch ALU operand A from the bus
//   GG        out  latch ALU result into G
//   ALU_OP    out  00 ADD, 01 SUB, 10 INV(B)
//   DONE      out  one-cycle pulse in the last state of each instruction
//   BUSY      out  high while executing (T1..T3)
//   ILLEGAL   out  high together with DONE for an unknown opcode
//   INSTR_CNT out  count of completed legal instructions (wraps)
// -----------------------------------------------------------------------------
module proc_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             CLKb,
  input  logic             RSTb,
  input  logic             EXEC,
  input  logic [9:0]       INSTR,
  output logic             ENW,
  output logic             ENR0,
  output logic             ENR1,
  output logic [1:0]       WRA,
  output logic [1:0]       RDA0,
  output logic [1:0]       RDA1,
  output logic             EXT,
  output logic             GOUT,
  output logic             GA,
  output logic             GG,
  output logic [1:0]       ALU_OP,
  output logic             DONE,
  output logic             BUSY,
  output logic             ILLEGAL,
  output logic [CNT_W-1:0] INSTR_CNT
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2,
    S_T3   = 2'd3
  } state_e;

  localparam logic [3:0] OP_LOAD = 4'b0000;
  localparam logic [3:0] OP_COPY = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_INV  = 4'b0100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_INV = 2'b10;

  state_e           state_q, state_d;
  // Only opcode, Rx and Ry are kept; INSTR[1:0] carries no meaning.
  logic [7:0]       ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] op;
  logic [1:0] rx;
  logic [1:0] ry;

  logic unused_instr_bits;
  assign unused_instr_bits = ^INSTR[1:0];

  assign op = ir_q[7:4];
  assign rx = ir_q[3:2];
  assign ry = ir_q[1:0];

  assign INSTR_CNT = cnt_q;

  // State, instruction register and completion counter.
  always_ff @(posedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. IR is only loaded on acceptance, so INSTR changes
  // while busy have no effect.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      S_IDLE: begin
        if (EXEC) begin
          ir_d    = INSTR[9:2];
          state_d = S_T1;
        end
      end
      S_T1: begin
        if (op == OP_ADD || op == OP_SUB || op == OP_INV) state_d = S_T2;
        else                                              state_d = S_IDLE;
      end
      S_T2: begin
        if (op == OP_ADD || op == OP_SUB) state_d = S_T3;
        else                              state_d = S_IDLE;
      end
      S_T3: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore output decode. Everything defaults to 0, which is also the IDLE
  // pattern; because reset forces IDLE asynchronously, outputs drop to 0 the
  // moment RSTb goes low.
  always_comb begin
    ENW     = 1'b0;
    ENR0    = 1'b0;
    ENR1    = 1'b0;
    WRA     = 2'b00;
    RDA0    = 2'b00;
    RDA1    = 2'b00;
    EXT     = 1'b0;
    GOUT    = 1'b0;
    GA      = 1'b0;
    GG      = 1'b0;
    ALU_OP  = ALU_ADD;
    DONE    = 1'b0;
    ILLEGAL = 1'b0;
    BUSY    = (state_q != S_IDLE);
    unique case (state_q)
      S_T1: begin
        unique case (op)
          OP_LOAD: begin
            EXT  = 1'b1;
            ENW  = 1'b1;
            WRA  = rx;
            DONE = 1'b1;
          end
          OP_COPY: begin
            ENR0 = 1'b1;
            RDA0 = ry;
            ENW  = 1'b1;
            WRA  = rx;
            DONE = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ENR0 = 1'b1;
            RDA0 = rx;
            GA   = 1'b1;
          end
          OP_INV: begin
            ENR1   = 1'b1;
            RDA1   = ry;
            ALU_OP = ALU_INV;
            GG     = 1'b1;
          end
          default: begin
            ILLEGAL = 1'b1;
            DONE    = 1'b1;
          end
        endcase
      end
      S_T2: begin
        if (op == OP_INV) begin
          GOUT = 1'b1;
          ENW  = 1'b1;
          WRA  = rx;
          DONE = 1'b1;
        end else begin
          ENR1   = 1'b1;
          RDA1   = ry;
          ALU_OP = (op == OP_SUB) ? ALU_SUB : ALU_ADD;
          GG     = 1'b1;
        end
      end
      S_T3: begin
        GOUT = 1'b1;
        ENW  = 1'b1;
        WRA  = rx;
        DONE = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Count on the edge that leaves a DONE state, but never for an illegal op.
  always_comb begin
    cnt_d = cnt_q;
    if (DONE && !ILLEGAL) cnt_d = cnt_q + CNT_W'(1);
  end

endmodule

// File: tb/tb_proc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_proc_sequencer
//   Table-driven bench for proc_sequencer with a small behavioural datapath
//   (4x8 register file written on the falling edge, A and G registers, ALU)
//   driven by the sequencer's control outputs. Expected per-cycle control
//   words and counter values are pushed to a scoreboard queue when an
//   instruction is issued and popped/compared just after each rising edge.
// -----------------------------------------------------------------------------
module tb_proc_sequencer;

  localparam int CNT_W = 2;

  // Field order of the packed control word (MSB first).
  typedef struct packed {
    logic       enw;
    logic       enr0;
    logic       enr1;
    logic [1:0] wra;
    logic [1:0] rda0;
    logic [1:0] rda1;
    logic       ext;
    logic       gout;
    logic       ga;
    logic       gg;
    logic [1:0] alu_op;
    logic       done;
    logic       busy;
    logic       illegal;
  } ctl_t;

  typedef struct packed {
    ctl_t             ctl;
    logic [CNT_W-1:0] cnt;
  } sb_t;

  typedef struct {
    logic [9:0] instr;
    logic [7:0] din;
    int         n;
    bit         legal;
    ctl_t       w [3];
    bit         chk_en;
    logic [1:0] chk_r;
    logic [7:0] chk_v;
  } vec_t;

  localparam ctl_t IDLE_W = 18'b0;

  logic             CLKb;
  logic             RSTb;
  logic             EXEC;
  logic [9:0]       INSTR;
  logic             ENW, ENR0, ENR1;
  logic [1:0]       WRA, RDA0, RDA1;
  logic             EXT, GOUT, GA, GG;
  logic [1:0]       ALU_OP;
  logic             DONE, BUSY, ILLEGAL;
  logic [CNT_W-1:0] INSTR_CNT;

  proc_sequencer #(.CNT_W(CNT_W)) dut (
    .CLKb     (CLKb),
    .RSTb     (RSTb),
    .EXEC     (EXEC),
    .INSTR    (INSTR),
    .ENW      (ENW),
    .ENR0     (ENR0),
    .ENR1     (ENR1),
    .WRA      (WRA),
    .RDA0     (RDA0),
    .RDA1     (RDA1),
    .EXT      (EXT),
    .GOUT     (GOUT),
    .GA       (GA),
    .GG       (GG),
    .ALU_OP   (ALU_OP),
    .DONE     (DONE),
    .BUSY     (BUSY),
    .ILLEGAL  (ILLEGAL),
    .INSTR_CNT(INSTR_CNT)
  );

  initial CLKb = 1'b0;
  always #5 CLKb = ~CLKb;

  ctl_t act;
  assign act = {ENW, ENR0, ENR1, WRA, RDA0, RDA1, EXT, GOUT, GA, GG,
                ALU_OP, DONE, BUSY, ILLEGAL};

  // ---------------- behavioural datapath ----------------
  logic [7:0] din;
  logic [7:0] rf [4];
  logic [7:0] a_reg, g_reg;
  logic [7:0] bus_w, rd1_w;

  always_comb begin
    bus_w = 8'h00;
    if (EXT)       bus_w = din;
    else if (GOUT) bus_w = g_reg;
    else if (ENR0) bus_w = rf[RDA0];
    rd1_w = ENR1 ? rf[RDA1] : 8'h00;
  end

  always @(posedge CLKb) begin
    if (GA) a_reg <= bus_w;
    if (GG) begin
      case (ALU_OP)
        2'b00:   g_reg <= a_reg + rd1_w;
        2'b01:   g_reg <= a_reg - rd1_w;
        default: g_reg <= ~rd1_w;
      endcase
    end
  end

  always @(negedge CLKb) begin
    if (ENW) rf[WRA] <= bus_w;
  end

  // ---------------- scoreboard ----------------
  int  n_checks = 0;
  int  n_fail   = 0;
  sb_t exp_q [$];
  logic [CNT_W-1:0] exp_cnt;

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, a, e, $time);
    end
  endtask

  always @(posedge CLKb) begin
    sb_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      $display("t=%0t ctl=%05h cnt=%0d exp_ctl=%05h exp_cnt=%0d",
               $time, act, INSTR_CNT, e.ctl, e.cnt);
      check("ctl", 32'(act), 32'(e.ctl));
      check("instr_cnt", 32'(INSTR_CNT), 32'(e.cnt));
      check("bus_onehot", 32'($countones({EXT, ENR0, GOUT}) <= 1), 32'd1);
    end
  end

  // Called at the falling edge of an IDLE cycle: accept at the next rising
  // edge, then hold EXEC high and scramble INSTR while busy. Returns at the
  // falling edge of the IDLE cycle after DONE.
  task automatic issue(input vec_t v);
    EXEC  = 1'b1;
    INSTR = v.instr;
    din   = v.din;
    for (int k = 0; k < v.n; k++) exp_q.push_back('{v.w[k], exp_cnt});
    if (v.legal) exp_cnt = exp_cnt + CNT_W'(1);
    exp_q.push_back('{IDLE_W, exp_cnt});
    @(negedge CLKb);
    for (int k = 0; k < v.n; k++) begin
      INSTR = 10'($urandom);
      @(negedge CLKb);
    end
    if (v.chk_en) check("reg", 32'(rf[v.chk_r]), 32'(v.chk_v));
  endtask

  task automatic idle(input int n);
    EXEC = 1'b0;
    for (int k = 0; k < n; k++) exp_q.push_back('{IDLE_W, exp_cnt});
    for (int k = 0; k < n; k++) @(negedge CLKb);
  endtask

  function automatic vec_t mkv(input logic [9:0] instr, input logic [7:0] d,
                               input int n, input bit legal,
                               input ctl_t w0, input ctl_t w1, input ctl_t w2,
                               input bit chk_en, input logic [1:0] chk_r,
                               input logic [7:0] chk_v);
    vec_t v;
    v.instr  = instr;
    v.din    = d;
    v.n      = n;
    v.legal  = legal;
    v.w[0]   = w0;
    v.w[1]   = w1;
    v.w[2]   = w2;
    v.chk_en = chk_en;
    v.chk_r  = chk_r;
    v.chk_v  = chk_v;
    return v;
  endfunction

  vec_t vecs [10];
  vec_t ld;

  initial begin
    // word fields: enw enr0 enr1 wra rda0 rda1 ext gout ga gg alu done busy ill
    vecs[0] = mkv(10'b0000_01_00_00, 8'h11, 1, 1'b1,                    // LOAD R1
                  18'b1_0_0_01_00_00_1_0_0_0_00_1_1_0, IDLE_W, IDLE_W, 1'b1, 2'd1, 8'h11);
    vecs[1] = mkv(10'b0000_10_00_00, 8'h05, 1, 1'b1,                    // LOAD R2=5
                  18'b1_0_0_10_00_00_1_0_0_0_00_1_1_0, IDLE_W, IDLE_W, 1'b1, 2'd2, 8'h05);
    vecs[2] = mkv(10'b0000_11_00_00, 8'h07, 1, 1'b1,                    // LOAD R3=7
                  18'b1_0_0_11_00_00_1_0_0_0_00_1_1_0, IDLE_W, IDLE_W, 1'b1, 2'd3, 8'h07);
    vecs[3] = mkv(10'b0010_10_11_00, 8'hAA, 3, 1'b1,                    // ADD R2,R3
                  18'b0_1_0_00_10_00_0_0_1_0_00_0_1_0,
                  18'b0_0_1_00_00_11_0_0_0_1_00_0_1_0,
                  18'b1_0_0_10_00_00_0_1_0_0_00_1_1_0, 1'b1, 2'd2, 8'd12);
    vecs[4] = mkv(10'b0001_00_10_00, 8'h55, 1, 1'b1,                    // COPY R0,R2
                  18'b1_1_0_00_10_00_0_0_0_0_00_1_1_0, IDLE_W, IDLE_W, 1'b1, 2'd0, 8'd12);
    vecs[5] = mkv(10'b0011_11_01_00, 8'h00, 3, 1'b1,                    // SUB R3,R1
                  18'b0_1_0_00_11_00_0_0_1_0_00_0_1_0,
                  18'b0_0_1_00_00_01_0_0_0_1_01_0_1_0,
                  18'b1_0_0_11_00_00_0_1_0_0_00_1_1_0, 1'b1, 2'd3, 8'hF6);
    vecs[6] = mkv(10'b0100_01_10_00, 8'h00, 2, 1'b1,                    // INV R1,R2
                  18'b0_0_1_00_00_10_0_0_0_1_10_0_1_0,
                  18'b1_0_0_01_00_00_0_1_0_0_00_1_1_0, IDLE_W, 1'b1, 2'd1, 8'hF3);
    vecs[7] = mkv(10'b0010_01_01_00, 8'h00, 3, 1'b1,                    // ADD R1,R1
                  18'b0_1_0_00_01_00_0_0_1_0_00_0_1_0,
                  18'b0_0_1_00_00_01_0_0_0_1_00_0_1_0,
                  18'b1_0_0_01_00_00_0_1_0_0_00_1_1_0, 1'b1, 2'd1, 8'hE6);
    vecs[8] = mkv(10'b1111_00_00_00, 8'h99, 1, 1'b0,                    // illegal
                  18'b0_0_0_00_00_00_0_0_0_0_00_1_1_1, IDLE_W, IDLE_W, 1'b1, 2'd0, 8'd12);
    vecs[9] = mkv(10'b0101_10_01_00, 8'h99, 1, 1'b0,                    // illegal
                  18'b0_0_0_00_00_00_0_0_0_0_00_1_1_1, IDLE_W, IDLE_W, 1'b1, 2'd2, 8'd12);

    // Reset with EXEC high and junk on INSTR: nothing may start.
    RSTb    = 1'b0;
    EXEC    = 1'b1;
    INSTR   = 10'b0000_01_00_00;
    din     = 8'h00;
    exp_cnt = '0;
    repeat (3) @(negedge CLKb);
    check("reset_ctl", 32'(act), 32'(IDLE_W));
    check("reset_cnt", 32'(INSTR_CNT), 32'd0);

    // First instruction accepted on the first rising edge after release;
    // every following one is issued in the IDLE cycle right after DONE.
    RSTb = 1'b1;
    for (int i = 0; i < 10; i++) issue(vecs[i]);
    idle(2);

    // Reset during T2 of SUB R1,R2 after one completed LOAD.
    ld = mkv(10'b0000_00_00_00, 8'h3C, 1, 1'b1,
             18'b1_0_0_00_00_00_1_0_0_0_00_1_1_0, IDLE_W, IDLE_W, 1'b1, 2'd0, 8'h3C);
    issue(ld);
    EXEC  = 1'b1;
    INSTR = 10'b0011_01_10_00;
    exp_q.push_back('{ctl_t'(18'b0_1_0_00_01_00_0_0_1_0_00_0_1_0), exp_cnt});
    exp_q.push_back('{ctl_t'(18'b0_0_1_00_00_10_0_0_0_1_01_0_1_0), exp_cnt});
    @(negedge CLKb);
    EXEC = 1'b0;
    @(negedge CLKb);
    #1 RSTb = 1'b0;
    #1;
    check("midrst_ctl", 32'(act), 32'(IDLE_W));
    check("midrst_cnt", 32'(INSTR_CNT), 32'd0);
    exp_cnt = '0;
    repeat (3) @(negedge CLKb);
    check("midrst_nowrite", 32'(rf[1]), 32'hE6);
    check("midrst_hold", 32'({act, INSTR_CNT}), 32'd0);
    RSTb = 1'b1;

    // Counter wrap with a 2-bit counter: 1, 2, 3, 0.
    for (int i = 0; i < 4; i++) begin
      ld = mkv(10'b0000_11_00_00, 8'(i + 1), 1, 1'b1,
               18'b1_0_0_11_00_00_1_0_0_0_00_1_1_0, IDLE_W, IDLE_W, 1'b1, 2'd3, 8'(i + 1));
      issue(ld);
    end
    check("wrap_cnt", 32'(INSTR_CNT), 32'd0);
    idle(3);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_sequencer.md
PROC_SEQUENCER -- requirements
Module: proc_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the completed-instruction counter.
REQ-002 SHALL have port CLKb, input, 1, the only clock; state updates on the rising edge; the register file writes on the falling edge.
REQ-003 SHALL have port RSTb, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port EXEC, input, 1, start request; sampled only in IDLE.
REQ-005 SHALL have port INSTR, input, 10, instruction: [9:6] opcode, [5:4] Rx, [3:2] Ry, [1:0] ignored.
REQ-006 SHALL have ports ENW, ENR0, ENR1, outputs, 1 each, register-file write and read enables.
REQ-007 SHALL have ports WRA, RDA0, RDA1, outputs, 2 each, register-file addresses.
REQ-008 SHALL have ports EXT, GOUT, outputs, 1 each, drive DIN or ALU result G onto the shared bus.
REQ-009 SHALL have ports GA and GG, outputs, 1 each; GA latches ALU operand A, GG latches result G.
REQ-010 SHALL have port ALU_OP, output, 2; encodings 00 ADD, 01 SUB, 10 INV(B).
REQ-011 SHALL have ports DONE, BUSY, ILLEGAL, outputs, 1 each, status.
REQ-012 SHALL have port INSTR_CNT, output, CNT_W, count of completed legal instructions.

Function
REQ-013 SHALL implement FSM states IDLE, T1, T2, T3; all control outputs SHALL be Moore, decoded from state and latched IR only.
REQ-014 SHALL, in IDLE with EXEC=1 at a rising edge, latch INSTR into IR and go to T1; with EXEC=0, stay in IDLE.
REQ-015 SHALL ignore EXEC and any INSTR change while not in IDLE.
REQ-016 SHALL, in IDLE, drive all enables, EXT, GOUT, GA, GG, DONE and ILLEGAL low, and BUSY low.
REQ-017 SHALL hold BUSY high in T1, T2 and T3.
REQ-018 SHALL execute LOAD (0000) in T1 only: EXT=1, ENW=1, WRA=Rx, DONE=1, then return to IDLE.
REQ-019 SHALL execute COPY (0001) in T1 only: ENR0=1, RDA0=Ry, ENW=1, WRA=Rx, DONE=1, then return to IDLE.
REQ-020 SHALL execute ADD (0010) and SUB (0011) in three states, then return to IDLE:
- T1: ENR0=1, RDA0=Rx, GA=1.
- T2: ENR1=1, RDA1=Ry, ALU_OP=00 (ADD) or 01 (SUB), GG=1.
- T3: GOUT=1, ENW=1, WRA=Rx, DONE=1.
REQ-021 SHALL execute INV (0100) in two states, then return to IDLE:
- T1: ENR1=1, RDA1=Ry, ALU_OP=10, GG=1.
- T2: GOUT=1, ENW=1, WRA=Rx, DONE=1.
REQ-022 SHALL treat opcodes 0101-1111 as illegal: T1 asserts ILLEGAL=1 and DONE=1, ENW stays 0, then return to IDLE.
REQ-023 SHALL pulse DONE for exactly one cycle per accepted instruction.
REQ-024 SHALL accept a new EXEC in the IDLE cycle that directly follows DONE; there is no dead cycle beyond IDLE.
REQ-025 SHALL keep ENW high for at most one state per instruction.
REQ-026 SHALL assert at most one of EXT, ENR0 and GOUT in any cycle.
REQ-027 SHALL drive address outputs that are not in use to 00.
REQ-028 SHALL increment INSTR_CNT by 1 on the rising edge that leaves a DONE state of a legal instruction, wrapping from 2^CNT_W-1 to 0.
REQ-029 SHALL NOT increment INSTR_CNT for an illegal opcode.
REQ-030 SHALL allow Rx=Ry for every opcode; ADD R1,R1 SHALL double R1.

Reset
REQ-031 SHALL, while RSTb=0, asynchronously force state to IDLE, IR to 0 and INSTR_CNT to 0, and drive all outputs to 0.
REQ-032 SHALL, on reset asserted mid-instruction, produce no further ENW, DONE or INSTR_CNT increment for that instruction.
REQ-033 SHALL sample EXEC from the first rising edge after RSTb deasserts.

Verification
REQ-034 SHALL cover LOAD: INSTR=0000_01_00_00, EXEC=1 -> in T1 EXT=1, ENW=1, WRA=01, DONE=1; next cycle IDLE; INSTR_CNT 0->1.
REQ-035 SHALL cover ADD R2,R3 with R2=5 and R3=7: INSTR=0010_10_11_00 -> T1 RDA0=10, GA=1; T2 RDA1=11, ALU_OP=00, GG=1; T3 GOUT=1, ENW=1, WRA=10; R2 reads 12.
REQ-036 SHALL cover illegal opcode: INSTR=1111_00_00_00 -> ILLEGAL=1 and DONE=1 for one cycle, no ENW, INSTR_CNT unchanged.
REQ-037 SHALL cover back-to-back: two legal instructions with EXEC held high -> the second is accepted in the IDLE cycle after the first DONE; INSTR_CNT advances by 2.
REQ-038 SHALL cover reset mid-operation: RSTb=0 during T2 of SUB -> all outputs 0 at once, no write to Rx, INSTR_CNT=0.
REQ-039 SHALL cover wrap: with CNT_W=2, four LOADs -> INSTR_CNT reads 1, 2, 3, 0.
